tcdm_bank_tas: RTL and testbench
================================

# tcdm_bank_tas

Per-bank adapter between one slave port of the TCDM crossbar and a single-port SRAM bank with 1-cycle read latency. It passes ordinary loads and stores straight through. It generates the response-valid strobe the crossbar consumes. It implements atomic test-and-set: one granted request returns the old word and writes all-ones in the following cycle, with no other access in between.

## Interface
- DataWidth, 32, data word width
- BeWidth, DataWidth/8, byte-enable width
- AddrMemWidth, 12, word address bits inside the bank

- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  1  request from crossbar slave port
- gnt_o  out  1  grant to crossbar
- add_i  in  AddrMemWidth  word address
- wen_i  in  1  0 = store, 1 = load
- wdata_i  in  DataWidth  store data
- be_i  in  BeWidth  byte enables
- ts_set_i  in  1  request is test-and-set (only meaningful with wen_i=1)
- vld_o  out  1  response valid, one cycle after grant
- rdata_o  out  DataWidth  response data
- mem_req_o  out  1  SRAM chip enable
- mem_wen_o  out  1  0 = write, 1 = read
- mem_add_o  out  AddrMemWidth  SRAM address
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_be_o  out  BeWidth  SRAM byte enables
- mem_rdata_i  in  DataWidth  SRAM read data, valid the cycle after a read

## Operation
- FSM with two states, IDLE and TAS_WB. Reset state is IDLE.
- IDLE:
  - gnt_o=1.
  - mem_req_o=req_i; mem_wen_o, mem_add_o, mem_wdata_o and mem_be_o come combinationally from the inputs.
- IDLE to TAS_WB when req_i & wen_i & ts_set_i:
  - The SRAM read is issued as a normal load.
  - add_i is captured into addr_q.
- TAS_WB:
  - gnt_o=0.
  - mem_req_o=1, mem_wen_o=0, mem_add_o=addr_q, mem_wdata_o='1, mem_be_o='1.
  - Unconditional return to IDLE on the next edge.
- ts_set_i with wen_i=0 is an ordinary store; ts_set_i is ignored and there is no state change.
- vld_o register: next value = mem_req_o & gnt_o. This pulses for every granted load, store and TAS. The TAS_WB write-back produces no vld_o.
- rdata_o = mem_rdata_i, unconditionally and combinationally. It is defined only when vld_o=1. For stores the value is don't-care.
- A request arriving during TAS_WB sees gnt_o=0. It must be held by the requester and is granted in the next IDLE cycle. This guarantees atomicity.

## Timing
- Reset values: vld_o=0, state=IDLE, addr_q=0. While rst_ni=0, gnt_o=0 and mem_req_o=0 (gated combinationally).
- Load or store: request and SRAM access in cycle N; vld_o=1 in N+1; load data on rdata_o in N+1.
- TAS:
  - Granted read in N.
  - In N+1: vld_o=1, rdata_o=old word, gnt_o=0, SRAM write of all-ones.
  - IDLE in N+2.
- Back-to-back TAS to the same address: the second is granted in N+2 and returns all-ones in N+3.
- Requests are accepted every cycle in IDLE: full throughput of 1 access/cycle except for the one TAS_WB bubble.
- Reset asserted during TAS_WB: state goes to IDLE immediately and mem_req_o drops, so the write-back is lost. The requester is reset as well.
- vld_o is registered; gnt_o is combinational from the state only (and rst_ni). There is no path from req_i to gnt_o.

## Configuration
- TCDM_BANK_TAS_EN:
  - Defined: test-and-set implemented as above.
  - Undefined: the FSM and addr_q are removed, gnt_o=1 out of reset, ts_set_i is ignored, and a TAS request behaves as a plain load (old word returned, no write-back).

## Test plan
- Reset: hold rst_ni=0 with req_i=1 -> gnt_o=0, mem_req_o=0, vld_o=0; release -> gnt_o=1 on the first cycle.
- Store then load to address 0x010: store wdata 0xDEADBEEF with be 0xF in cycle N, load in N+1 -> vld_o=1 in N+1 and N+2; rdata_o=0xDEADBEEF in N+2.
- Partial store: be=0x3 with wdata 0x0000_1234 over 0xDEADBEEF -> subsequent load returns 0xDEAD1234.
- TAS on a word holding 0x00000000:
  - rdata_o=0x00000000 with vld_o in N+1.
  - gnt_o=0 in N+1.
  - A second TAS held on req_i is granted in N+2 and returns 0xFFFFFFFF in N+3.
- TAS followed by a load to a different address held from N+1: the load is granted in N+2, not N+1; returns correct data; exactly 3 vld_o pulses total across N..N+3.
- Reset pulse asserted in TAS_WB: no SRAM write is observed; a following load to the TAS address returns the old value (0x00000000).
- With TCDM_BANK_TAS_EN undefined, TAS on 0x00000000 -> returns 0x00000000; gnt_o stays 1 throughout; a following load also returns 0x00000000.

Source files
------------

// File: rtl/tcdm_bank_tas.sv
// TCDM bank adapter: crossbar slave port to 1-cycle SRAM, with test-and-set.
// Test-and-set is built only when TCDM_BANK_TAS_EN is defined.
module tcdm_bank_tas #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned BeWidth      = DataWidth / 8,
    parameter int unsigned AddrMemWidth = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [AddrMemWidth-1:0] add_i,
    input  logic                    wen_i,
    input  logic [DataWidth-1:0]    wdata_i,
    input  logic [BeWidth-1:0]      be_i,
    input  logic                    ts_set_i,
    output logic                    vld_o,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_wen_o,
    output logic [AddrMemWidth-1:0] mem_add_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic [BeWidth-1:0]      mem_be_o,
    input  logic [DataWidth-1:0]    mem_rdata_i
);

    logic                    tas_wb;
    logic [AddrMemWidth-1:0] wb_add;

`ifdef TCDM_BANK_TAS_EN
    typedef enum logic {
        IDLE,
        TAS_WB
    } state_t;

    state_t                  state_q;
    logic [AddrMemWidth-1:0] addr_q;

    // The TAS read goes out as a plain load; the write-back owns the next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i && wen_i && ts_set_i) begin
                        state_q <= TAS_WB;
                        addr_q  <= add_i;
                    end
                end
                TAS_WB:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tas_wb = (state_q == TAS_WB);
    assign wb_add = addr_q;
`else
    logic unused_ts;

    assign unused_ts = ts_set_i;
    assign tas_wb    = 1'b0;
    assign wb_add    = add_i;
`endif

    // Grant depends only on state so no req_i->gnt_o path exists.
    assign gnt_o       = rst_ni & ~tas_wb;
    assign mem_req_o   = rst_ni & (req_i | tas_wb);
    assign mem_wen_o   = tas_wb ? 1'b0 : wen_i;
    assign mem_add_o   = tas_wb ? wb_add : add_i;
    assign mem_wdata_o = tas_wb ? {DataWidth{1'b1}} : wdata_i;
    assign mem_be_o    = tas_wb ? {BeWidth{1'b1}} : be_i;
    assign rdata_o     = mem_rdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_o <= 1'b0;
        end else begin
            vld_o <= mem_req_o & gnt_o;
        end
    end

endmodule

// File: tb/tb_tcdm_bank_tas.sv
// Directed bench for tcdm_bank_tas: SRAM model plus reference-memory scoreboard.
// Expectations follow TCDM_BANK_TAS_EN when it is defined at compile time.
module tb_tcdm_bank_tas;

`ifdef TCDM_BANK_TAS_EN
    localparam bit TasEn = 1'b1;
`else
    localparam bit TasEn = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b1;
    logic        gnt_o;
    logic [11:0] add_i = '0;
    logic        wen_i = 1'b1;
    logic [31:0] wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic        ts_set_i = 1'b0;
    logic        vld_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic        mem_wen_o;
    logic [11:0] mem_add_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    tcdm_bank_tas dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .add_i       (add_i),
        .wen_i       (wen_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .ts_set_i    (ts_set_i),
        .vld_o       (vld_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_wen_o   (mem_wen_o),
        .mem_add_o   (mem_add_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_rdata_i (mem_rdata_i)
    );

    function automatic logic [31:0] merge(
        logic [31:0] o, logic [31:0] w, logic [3:0] be);
        for (int i = 0; i < 4; i++)
            if (be[i]) o[8*i +: 8] = w[8*i +: 8];
        return o;
    endfunction

    // Behavioural single-port SRAM, unwritten words read as zero
    logic [31:0] sram [logic [11:0]];
    int          wr50 = 0;

    always @(posedge clk_i) begin : sram_model
        logic [31:0] cur;
        if (mem_req_o === 1'b1) begin
            cur = sram.exists(mem_add_o) ? sram[mem_add_o] : 32'h0;
            if (mem_wen_o === 1'b0) begin
                sram[mem_add_o] = merge(cur, mem_wdata_o, mem_be_o);
                if (mem_add_o == 12'h050) wr50++;
            end else begin
                mem_rdata_i <= cur;
            end
        end
    end

    typedef struct {
        bit          is_load;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] refm [logic [11:0]];
    int          tests = 0;
    int          fails = 0;
    bit          last_g = 1'b0;
    bit          pend_v = 1'b0;
    logic [11:0] pend_a = '0;
    int          vld_cnt = 0;
    logic [31:0] last_rdata = '0;

    function automatic logic [31:0] rd_ref(logic [11:0] a);
        return refm.exists(a) ? refm[a] : 32'h0;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: sample last cycle's response, then drive and check
    task automatic step(
        input logic rst, input logic req, input logic wen, input logic ts,
        input logic [11:0] a, input logic [31:0] wd, input logic [3:0] be,
        output bit g);
        bit          wb;
        bit          eg;
        logic [11:0] wa;
        exp_t        e;
        @(negedge clk_i);
        check("vld", {31'b0, vld_o}, {31'b0, last_g});
        if (vld_o === 1'b1) begin
            vld_cnt++;
            last_rdata = rdata_o;
            check("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.is_load) check("rdata", rdata_o, e.data);
            end
        end
        #1;
        wb = pend_v;
        wa = pend_a;
        if (pend_v && rst) refm[pend_a] = 32'hFFFF_FFFF;
        pend_v   = 1'b0;
        rst_ni   = rst;
        req_i    = req;
        wen_i    = wen;
        ts_set_i = ts;
        add_i    = a;
        wdata_i  = wd;
        be_i     = be;
        #1;
        eg = rst && !wb;
        check("gnt", {31'b0, gnt_o}, {31'b0, eg});
        check("mem_req", {31'b0, mem_req_o}, {31'b0, rst && (req || wb)});
        if (wb && rst) begin
            check("wb_wen", {31'b0, mem_wen_o}, 32'd0);
            check("wb_add", {20'b0, mem_add_o}, {20'b0, wa});
            check("wb_data", mem_wdata_o, 32'hFFFF_FFFF);
        end
        g = req && eg;
        if (g) begin
            check("mem_add", {20'b0, mem_add_o}, {20'b0, a});
            if (!wen) begin
                refm[a]   = merge(rd_ref(a), wd, be);
                e.is_load = 1'b0;
                e.data    = 32'h0;
            end else begin
                e.is_load = 1'b1;
                e.data    = rd_ref(a);
                if (TasEn && ts) begin
                    pend_v = 1'b1;
                    pend_a = a;
                end
            end
            sb.push_back(e);
        end
        last_g = g;
    endtask

    task automatic idle();
        bit g;
        step(1'b1, 1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 4'h0, g);
    endtask

    initial begin : seq
        bit g;
        int n;
        int c0;

        // Reset held with a pending request
        step(1'b0, 1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0, g);
        step(1'b0, 1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0, g);
        idle();

        // Full store then load
        step(1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 32'hDEAD_BEEF, 4'hF, g);
        step(1'b1, 1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0, g);
        idle();
        check("ld_beef", last_rdata, 32'hDEAD_BEEF);

        // Partial store
        step(1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0000_1234, 4'h3, g);
        step(1'b1, 1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0, g);
        idle();
        check("ld_partial", last_rdata, 32'hDEAD_1234);

        // ts_set_i on a store is an ordinary store
        step(1'b1, 1'b1, 1'b0, 1'b1, 12'h060, 32'h1234_5678, 4'hF, g);
        step(1'b1, 1'b1, 1'b1, 1'b0, 12'h060, 32'h0, 4'h0, g);
        idle();
        check("ts_store", last_rdata, 32'h1234_5678);

        // Back-to-back TAS on a zero word
        step(1'b1, 1'b1, 1'b1, 1'b1, 12'h020, 32'h0, 4'h0, g);
        step(1'b1, 1'b1, 1'b1, 1'b1, 12'h020, 32'h0, 4'h0, g);
        n = 1;
        check("tas1_old", last_rdata, 32'h0);
        while (!g && n < 4) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 12'h020, 32'h0, 4'h0, g);
            n++;
        end
        check("tas2_tries", n, TasEn ? 32'd2 : 32'd1);
        idle();
        check("tas2_val", last_rdata, TasEn ? 32'hFFFF_FFFF : 32'h0);
        idle();
        step(1'b1, 1'b1, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0, g);
        idle();
        check("tas_after", last_rdata, TasEn ? 32'hFFFF_FFFF : 32'h0);

        // TAS then a held load elsewhere; count pulses over N..N+3
        step(1'b1, 1'b1, 1'b0, 1'b0, 12'h040, 32'h55AA_55AA, 4'hF, g);
        c0 = vld_cnt;
        step(1'b1, 1'b1, 1'b1, 1'b1, 12'h030, 32'h0, 4'h0, g);
        step(1'b1, 1'b1, 1'b1, 1'b0, 12'h040, 32'h0, 4'h0, g);
        n = 2;
        while (!g && n < 5) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 12'h040, 32'h0, 4'h0, g);
            n++;
        end
        check("ld_grant_cyc", n, TasEn ? 32'd3 : 32'd2);
        while (n < 4) begin
            idle();
            n++;
        end
        check("vld_pulses", vld_cnt - c0, 32'd3);
        check("ld_after_tas", last_rdata, 32'h55AA_55AA);

        // Reset during the write-back slot drops the write
        step(1'b1, 1'b1, 1'b1, 1'b1, 12'h050, 32'h0, 4'h0, g);
        step(1'b0, 1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 4'h0, g);
        idle();
        step(1'b1, 1'b1, 1'b1, 1'b0, 12'h050, 32'h0, 4'h0, g);
        idle();
        check("rst_wb_val", last_rdata, 32'h0);
        check("rst_wb_wr", wr50, 32'd0);

        idle();
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
